hub75_bcm_scanner: RTL and testbench
====================================

// Module: hub75_bcm_scanner
// PURPOSE
//  Drives a HUB75 LED matrix panel from a pixel RAM using binary-coded modulation (BCM).
//  - Sits directly downstream of the per-channel gamma LUTs: rd_data carries
//    already gamma-corrected 8-bit R/G/B for two pixels, one from the top half and one
//    from the bottom half of the panel.
//  - For each row pair and each bit-plane, it shifts out one column of bits at a time,
//    latches the row, then enables the LEDs for a time weighted by the bit's significance.
// PARAMETERS
//  COLS       64  panel columns; power of two, >=2
//  ROWS_HALF  16  row pairs (number of hub_addr codes); power of two, >=2
//  BITS        8  BCM planes; plane p uses bit p of each colour byte; 1..8
//  OE_UNIT     1  clocks of LED-on time for plane 0; plane p gets OE_UNIT<<p clocks
//  local: CW=$clog2(COLS), RW=$clog2(ROWS_HALF)
// PORTS
//  clk       in   1      system clock
//  rst       in   1      synchronous, active-high reset
//  en        in   1      run enable
//  rd_addr   out  RW+CW  pixel RAM address {row,col}; registered
//  rd_data   in   48     {r_top,g_top,b_top,r_bot,g_bot,b_bot}; 8 bits each, MSB first
//                        valid the cycle after rd_addr changes (synchronous RAM)
//  hub_clk   out  1      panel shift clock
//  hub_lat   out  1      panel latch
//  hub_oe_n  out  1      panel output enable, active low
//  hub_addr  out  RW     panel row select
//  hub_rgb   out  6      {r1,g1,b1,r2,g2,b2}
//  frame_done out 1      one-cycle pulse at end of each frame
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: IDLE state; row=plane=col=0; rd_addr=0; hub_clk=0; hub_lat=0;
//    hub_oe_n=1; hub_addr=0; hub_rgb=0; frame_done=0.
//  - Reset mid-operation returns to these values on the next edge, with no flush.
//  - States and transitions:
//    - IDLE: hub_oe_n=1. If en=1, go to SHIFT with col=0, plane=0, row=0.
//    - SHIFT: each column takes 3 cycles; hub_oe_n=1 throughout.
//      - ph0: rd_addr={row,col}; hub_clk=0.
//      - ph1: hub_clk=0; hub_rgb <= bit[plane] of each rd_data byte.
//      - ph2: hub_clk=1; hub_rgb held.
//      - After ph2 of col=COLS-1, go to LATCH; otherwise col++ and return to ph0.
//    - LATCH: 1 cycle; hub_lat=1, hub_clk=0, hub_addr<=row, hub_oe_n=1.
//    - DISPLAY: hub_oe_n=0 for exactly OE_UNIT<<plane cycles. Then:
//      - If plane<BITS-1: plane++, go to SHIFT.
//      - Else plane=0. If row<ROWS_HALF-1: row++, go to SHIFT.
//      - Else row=0 (wrap) and frame_done=1 on the last DISPLAY cycle. Next state is
//        SHIFT if en=1, IDLE if en=0.
//  - en is sampled only in IDLE and at frame end. Deasserting en mid-frame completes
//    the frame.
//  - hub_addr changes only in LATCH, while the LEDs are blanked.
//  - Per-plane cycle count: 3*COLS + 1 + (OE_UNIT<<plane).
//  - Frame period: ROWS_HALF * sum over planes.
//  - The display counter must hold OE_UNIT<<(BITS-1) without overflow.
// TESTING (bench: COLS=4, ROWS_HALF=2, BITS=2, OE_UNIT=1; RAM model with 1-cycle latency)
//  1. Reset held 3 cycles, then released with en=0 -> outputs hold reset values;
//     hub_oe_n=1 and frame_done never pulses.
//  2. en=1, all pixels 0xFF -> per column, hub_rgb=6'h3F before the hub_clk rising edge;
//     4 hub_clk pulses per plane; hub_lat pulses every 14/15 cycles (plane 0/plane 1);
//     hub_oe_n low for 1 then 2 cycles.
//  3. Top pixel=0x01, bottom=0x02 -> plane0 hub_rgb=6'b111000, plane1=6'b000111.
//  4. en held high -> frame_done pulses every 58 cycles; hub_addr goes 0,1,0 (wrap),
//     changing only in hub_lat cycles.
//  5. en dropped mid-frame -> frame completes, frame_done pulses, state returns to IDLE
//     with hub_oe_n=1.
//  6. rst asserted during DISPLAY -> next cycle hub_oe_n=1, hub_addr=0, rd_addr=0;
//     restart from row 0, plane 0.

Source files
------------

// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: HUB75 panel driver with binary-coded modulation read from a synchronous pixel RAM
module hub75_bcm_scanner #(
  parameter int COLS      = 64,
  parameter int ROWS_HALF = 16,
  parameter int BITS      = 8,
  parameter int OE_UNIT   = 1,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS_HALF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [RW+CW-1:0]    rd_addr,
  input  logic [47:0]         rd_data,
  output logic                hub_clk,
  output logic                hub_lat,
  output logic                hub_oe_n,
  output logic [RW-1:0]       hub_addr,
  output logic [5:0]          hub_rgb,
  output logic                frame_done
);
  localparam int PW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int DW = $clog2((OE_UNIT << (BITS - 1)) + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;
  state_t st, st_n;
  logic [1:0] ph, ph_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [PW-1:0] plane, plane_n;
  logic [DW-1:0] dcnt, dcnt_n, oe_last;
  logic [2:0] pidx;
  logic [7:0] byte_s [6];
  logic [5:0] bits;
  logic frame_end;
  assign oe_last = DW'((OE_UNIT << plane) - 1);
  assign pidx = 3'(plane);
  // byte 0 is b_bot, so bit i of the plane slice lands on hub_rgb[i]
  for (genvar i = 0; i < 6; i++) begin : g_bits
    assign byte_s[i] = rd_data[8*i +: 8];
    assign bits[i] = byte_s[i][pidx];
  end
  always_comb begin
    st_n = st;
    ph_n = ph;
    col_n = col;
    row_n = row;
    plane_n = plane;
    dcnt_n = dcnt;
    case (st)
      IDLE: if (en) begin
        st_n = SHIFT;
        ph_n = '0;
        col_n = '0;
        row_n = '0;
        plane_n = '0;
      end
      SHIFT: begin
        ph_n = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
        if (ph == 2'd2) begin
          col_n = col + 1'b1;
          st_n = (col == CW'(COLS - 1)) ? LATCH : SHIFT;
        end
      end
      LATCH: begin
        st_n = DISPLAY;
        dcnt_n = '0;
      end
      DISPLAY: begin
        dcnt_n = dcnt + 1'b1;
        if (dcnt == oe_last) begin
          dcnt_n = '0;
          st_n = SHIFT;
          if (plane == PW'(BITS - 1)) begin
            plane_n = '0;
            row_n = row + 1'b1;
            if (row == RW'(ROWS_HALF - 1)) st_n = en ? SHIFT : IDLE;
          end else begin
            plane_n = plane + 1'b1;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end
  // outputs are registered from next-state values so each phase shows its own levels
  assign frame_end = (st_n == DISPLAY) && (dcnt_n == oe_last) &&
                     (plane == PW'(BITS - 1)) && (row == RW'(ROWS_HALF - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      ph <= '0;
      col <= '0;
      row <= '0;
      plane <= '0;
      dcnt <= '0;
      rd_addr <= '0;
      hub_clk <= 1'b0;
      hub_lat <= 1'b0;
      hub_oe_n <= 1'b1;
      hub_addr <= '0;
      hub_rgb <= '0;
      frame_done <= 1'b0;
    end else begin
      st <= st_n;
      ph <= ph_n;
      col <= col_n;
      row <= row_n;
      plane <= plane_n;
      dcnt <= dcnt_n;
      rd_addr <= (st_n == SHIFT && ph_n == 2'd0) ? {row_n, col_n} : rd_addr;
      hub_clk <= (st_n == SHIFT) && (ph_n == 2'd2);
      hub_rgb <= (st == SHIFT && ph == 2'd1) ? bits : hub_rgb;
      hub_lat <= (st_n == LATCH);
      hub_addr <= (st_n == LATCH) ? row_n : hub_addr;
      hub_oe_n <= (st_n != DISPLAY);
      frame_done <= frame_end;
    end
  end
endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// tb_hub75_bcm_scanner: directed vectors and timing sequences for the HUB75 BCM scanner
module tb_hub75_bcm_scanner;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [2:0] rd_addr;
  logic [47:0] rd_data;
  logic hub_clk, hub_lat, hub_oe_n, frame_done;
  logic [0:0] hub_addr;
  logic [5:0] hub_rgb;
  logic [47:0] mem [8];
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];
  hub75_bcm_scanner #(.COLS(4), .ROWS_HALF(2), .BITS(2), .OE_UNIT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n), .hub_addr(hub_addr),
    .hub_rgb(hub_rgb), .frame_done(frame_done));
  int cyc = 0, clk_cnt = 0, oe_run = 0, bad_addr = 0, bad_ov = 0;
  logic prev_addr = 1'b0;
  int lat_t[$], fd_t[$], clk_per_lat[$], oe_runs[$];
  logic lat_a[$];
  logic [5:0] rgbq[$];
  always @(negedge clk) begin
    cyc++;
    if (hub_clk === 1'b1) begin
      rgbq.push_back(hub_rgb);
      clk_cnt++;
    end
    if (hub_lat === 1'b1) begin
      lat_t.push_back(cyc);
      lat_a.push_back(hub_addr[0]);
      clk_per_lat.push_back(clk_cnt);
      clk_cnt = 0;
    end
    if (hub_oe_n === 1'b0) oe_run++;
    else if (oe_run > 0) begin
      oe_runs.push_back(oe_run);
      oe_run = 0;
    end
    if (frame_done === 1'b1) fd_t.push_back(cyc);
    if (hub_addr[0] !== prev_addr && hub_lat !== 1'b1 && rst !== 1'b1) bad_addr++;
    prev_addr = hub_addr[0];
    if (hub_oe_n === 1'b0 && (hub_clk === 1'b1 || hub_lat === 1'b1)) bad_ov++;
  end
  int pass_n = 0, total_n = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic fill(input logic [47:0] p);
    for (int i = 0; i < 8; i++) mem[i] = p;
  endtask
  typedef struct {logic [47:0] pix; int plane; logic [5:0] rgb;} vec_t;
  vec_t vt[6];
  int lb, ob, fb, rb, ba, bo, c0, n, bad;
  initial begin
    vt[0] = '{48'hFFFF_FFFF_FFFF, 0, 6'h3F};
    vt[1] = '{48'hFFFF_FFFF_FFFF, 1, 6'h3F};
    vt[2] = '{48'h0101_0102_0202, 0, 6'b111000};
    vt[3] = '{48'h0101_0102_0202, 1, 6'b000111};
    vt[4] = '{48'h0102_0300_0201, 0, 6'b101001};
    vt[5] = '{48'h0102_0300_0201, 1, 6'b011010};
    fill('0);
    tick(3);
    rst = 1'b0;
    tick(20);
    chk("idle_oe_n", hub_oe_n, 1);
    chk("idle_clk", hub_clk, 0);
    chk("idle_lat", hub_lat, 0);
    chk("idle_addr", hub_addr, 0);
    chk("idle_rgb", hub_rgb, 0);
    chk("idle_rd_addr", rd_addr, 0);
    chk("idle_no_frame_done", fd_t.size(), 0);
    chk("idle_no_oe", oe_runs.size(), 0);
    fill('1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b1;
    c0 = cyc; lb = lat_t.size(); ob = oe_runs.size(); fb = fd_t.size();
    rb = rgbq.size(); ba = bad_addr; bo = bad_ov;
    tick(130);
    chk("first_lat_cycle", lat_t[lb] - c0, 13);
    chk("lat_gap_p0", lat_t[lb+1] - lat_t[lb], 14);
    chk("lat_gap_p1", lat_t[lb+2] - lat_t[lb+1], 15);
    chk("clk_pulses_p1", clk_per_lat[lb+1], 4);
    chk("clk_pulses_p0", clk_per_lat[lb+2], 4);
    chk("oe_run_p0", oe_runs[ob], 1);
    chk("oe_run_p1", oe_runs[ob+1], 2);
    chk("frame_done_count", fd_t.size() - fb, 2);
    chk("frame_period", fd_t[fb+1] - fd_t[fb], 58);
    chk("frame_done_offset", fd_t[fb] - lat_t[lb], 45);
    chk("addr_seq", {lat_a[lb], lat_a[lb+1], lat_a[lb+2], lat_a[lb+3], lat_a[lb+4]}, 5'b00110);
    chk("addr_outside_lat", bad_addr - ba, 0);
    chk("oe_overlap", bad_ov - bo, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rgbq[rb+i] !== 6'h3F) bad++;
    chk("rgb_all_ff", bad, 0);
    for (int v = 0; v < 6; v++) begin
      fill(vt[v].pix);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en = 1'b1;
      rb = rgbq.size();
      n = 0;
      while (rgbq.size() < rb + 8 && n < 80) begin tick(); n++; end
      for (int c = 0; c < 4; c++)
        chk($sformatf("vec%0d_col%0d", v, c), rgbq[rb + vt[v].plane*4 + c], vt[v].rgb);
      en = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b1;
    c0 = cyc; fb = fd_t.size();
    tick(20);
    en = 1'b0;
    n = 0;
    while (fd_t.size() == fb && n < 100) begin tick(); n++; end
    chk("drop_en_frame_done", fd_t.size() - fb, 1);
    chk("drop_en_fd_cycle", (fd_t.size() > fb) ? fd_t[fb] - c0 : -1, 58);
    tick(2);
    lb = lat_t.size();
    chk("drop_en_idle_oe", hub_oe_n, 1);
    tick(40);
    chk("drop_en_no_restart", lat_t.size() - lb, 0);
    chk("drop_en_still_blank", hub_oe_n, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en = 1'b1;
    n = 0;
    while (!(hub_oe_n === 1'b0 && hub_addr === 1'b1) && n < 200) begin tick(); n++; end
    chk("reach_row1_display", n < 200, 1);
    rst = 1'b1;
    tick();
    chk("rst_oe_n", hub_oe_n, 1);
    chk("rst_addr", hub_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_lat", hub_lat, 0);
    rst = 1'b0;
    c0 = cyc; lb = lat_t.size(); ol_set();
    n = 0;
    while (lat_t.size() == lb && n < 60) begin tick(); n++; end
    chk("restart_lat_cycle", (lat_t.size() > lb) ? lat_t[lb] - c0 : -1, 13);
    chk("restart_lat_addr", (lat_t.size() > lb) ? lat_a[lb] : 1'bx, 0);
    tick(5);
    chk("restart_oe_p0", (oe_runs.size() > ob) ? oe_runs[ob] : -1, 1);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
  task automatic ol_set();
    ob = oe_runs.size();
  endtask
endmodule
